seven_seg_scan_driver: RTL and testbench

- Consumer of the 16-bit BCD `displayDigits` bus produced by the clock and alarm hour/minute counters.
- Time-multiplexes the four BCD digits onto one active-low 7-segment bus plus 4 active-low anodes.
- Blinks the field currently being edited (minutes or hours) using the same 2-bit field-select encoding as the counters.
- Sits between the counter/mux logic and the board's 4-digit display.

---
 rtl/display_pkg.sv | 26 ++
 rtl/bcd_to_seven_seg.sv | 26 ++
 rtl/seven_seg_scan_driver.sv | 111 +++++++++++
 tb/tb_seven_seg_scan_driver.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared 7-segment display constants
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [1:0] SEL_MIN = 2'b11;
  localparam logic [1:0] SEL_HR  = 2'b10;

  localparam logic [1:0] DIG_MIN_ONES = 2'd0;
  localparam logic [1:0] DIG_MIN_TENS = 2'd1;
  localparam logic [1:0] DIG_HR_ONES  = 2'd2;
  localparam logic [1:0] DIG_HR_TENS  = 2'd3;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// rtl/bcd_to_seven_seg.sv - BCD nibble to active-low 7-segment pattern
module bcd_to_seven_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - 4-digit multiplexed 7-segment driver with field blink
module seven_seg_scan_driver
  import display_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000,
  parameter bit LZ_BLANK  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] displayDigits,
  input  logic [1:0]  blinkSel,
  input  logic [3:0]  dpMask,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [3:0]  anode
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [1:0]    blink_sel_q;

  logic          scan_tick;
  logic          blink_wrap;
  logic          sel_change;

  assign scan_tick  = (prescaler == PW'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));
  assign sel_change = (blinkSel != blink_sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      blink_sel_q <= '0;
    end else if (en) begin
      prescaler <= scan_tick ? '0 : prescaler + 1'b1;
      if (scan_tick) begin
        idx <= idx + 1'b1;
      end
      blink_sel_q <= blinkSel;
      // A field change restarts the blink so the new field shows immediately
      if (sel_change) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_wrap) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  logic [3:0] digit;
  logic [6:0] digit_seg;
  logic       phase_eff;
  logic       in_field;
  logic       slot_off;
  logic [6:0] seg_d;
  logic [3:0] anode_d;
  logic       dp_d;

  assign digit = displayDigits[{idx, 2'b00} +: 4];

  bcd_to_seven_seg u_decode (
    .bcd (digit),
    .seg (digit_seg)
  );

  always_comb begin
    phase_eff = blink_phase & ~sel_change;
    in_field  = ((blinkSel == SEL_MIN) && (idx == DIG_MIN_ONES || idx == DIG_MIN_TENS)) ||
                ((blinkSel == SEL_HR)  && (idx == DIG_HR_ONES  || idx == DIG_HR_TENS));
    slot_off  = phase_eff & in_field;

    seg_d = digit_seg;
    if (LZ_BLANK && (idx == DIG_HR_TENS) && (digit == 4'd0)) begin
      seg_d = SEG_BLANK;
    end
    anode_d = slot_off ? 4'b1111 : ~(4'b0001 << idx);
    dp_d    = slot_off ? 1'b1 : ~dpMask[idx];

    if (!en) begin
      seg_d   = SEG_BLANK;
      anode_d = 4'b1111;
      dp_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segments <= SEG_BLANK;
      anode    <= 4'b1111;
      dp       <= 1'b1;
    end else begin
      segments <= seg_d;
      anode    <= anode_d;
      dp       <= dp_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] displayDigits;
  logic [1:0]  blinkSel;
  logic [3:0]  dpMask;
  logic [6:0]  segments, segments_nolz;
  logic        dp, dp_nolz;
  logic [3:0]  anode, anode_nolz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(32), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .displayDigits(displayDigits),
    .blinkSel(blinkSel), .dpMask(dpMask),
    .segments(segments), .dp(dp), .anode(anode)
  );

  seven_seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(32), .LZ_BLANK(1'b0)) dut_nolz (
    .clk(clk), .rst(rst), .en(en), .displayDigits(displayDigits),
    .blinkSel(blinkSel), .dpMask(dpMask),
    .segments(segments_nolz), .dp(dp_nolz), .anode(anode_nolz)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [6:0] seg_1234 [4];
  logic [6:0] seg_0a59 [4];
  logic [3:0] exp_anode;
  logic       exp_dp;
  logic       off;
  int         slot;

  initial begin
    seg_1234[0] = 7'b0011001; seg_1234[1] = 7'b0110000;
    seg_1234[2] = 7'b0100100; seg_1234[3] = 7'b1111001;
    seg_0a59[0] = 7'b0010000; seg_0a59[1] = 7'b0010010;
    seg_0a59[2] = 7'h7F;      seg_0a59[3] = 7'h7F;

    rst = 1'b1; en = 1'b1; displayDigits = 16'h1234; blinkSel = 2'b00; dpMask = 4'b0100;

    // Reset state, then one full scan plus wrap
    do_reset();
    chk("reset_anode", anode, 4'b1111);
    chk("reset_seg", segments, 7'h7F);
    chk("reset_dp", dp, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      step();
      slot = ((k - 1) / 4) % 4;
      exp_anode = ~(4'b0001 << slot);
      chk($sformatf("scan_anode_k%0d", k), anode, exp_anode);
      chk($sformatf("scan_seg_k%0d", k), segments, seg_1234[slot]);
      chk($sformatf("scan_dp_k%0d", k), dp, (slot == 2) ? 1'b0 : 1'b1);
    end

    // Enable gating mid-slot at idx 2
    do_reset();
    for (int k = 1; k <= 10; k++) step();
    en = 1'b0;
    for (int k = 11; k <= 20; k++) begin
      step();
      chk($sformatf("en_off_anode_k%0d", k), anode, 4'b1111);
      chk($sformatf("en_off_seg_k%0d", k), segments, 7'h7F);
      chk($sformatf("en_off_dp_k%0d", k), dp, 1'b1);
    end
    en = 1'b1;
    step();
    chk("en_resume1", anode, 4'b1011);
    step();
    chk("en_resume2", anode, 4'b1011);
    step();
    chk("en_resume_next", anode, 4'b0111);

    // Invalid nibble and leading-zero blank
    displayDigits = 16'h0A59;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step();
      slot = ((k - 1) / 4) % 4;
      exp_anode = ~(4'b0001 << slot);
      chk($sformatf("lz_anode_k%0d", k), anode, exp_anode);
      chk($sformatf("lz_seg_k%0d", k), segments, seg_0a59[slot]);
      if (slot == 3) chk($sformatf("nolz_seg_k%0d", k), segments_nolz, 7'b1000000);
    end

    // Minutes blink, then switch to hours blink
    displayDigits = 16'h1234;
    blinkSel = 2'b11;
    do_reset();
    for (int k = 1; k <= 79; k++) begin
      if (k == 41) blinkSel = 2'b10;
      step();
      slot = ((k - 1) / 4) % 4;
      if (k <= 40) off = (k >= 34) && (slot < 2);
      else         off = (k >= 74) && (slot >= 2);
      exp_anode = off ? 4'b1111 : ~(4'b0001 << slot);
      exp_dp    = off ? 1'b1 : ((slot == 2) ? 1'b0 : 1'b1);
      chk($sformatf("blink_anode_k%0d", k), anode, exp_anode);
      chk($sformatf("blink_dp_k%0d", k), dp, exp_dp);
    end

    // Reset at idx 3 with blink phase high
    rst = 1'b1;
    blinkSel = 2'b11;
    step();
    chk("midrst_anode", anode, 4'b1111);
    chk("midrst_seg", segments, 7'h7F);
    chk("midrst_dp", dp, 1'b1);
    rst = 1'b0;
    step();
    chk("postrst_anode", anode, 4'b1110);
    chk("postrst_seg", segments, 7'b0011001);
    chk("postrst_dp", dp, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
